sha256_hash_engine: RTL and testbench
=====================================

// Module: sha256_hash_engine
// PURPOSE
//  Command-driven SHA-256 compression datapath. It responds to the per-cycle commands issued by the mining control
//  block: start, c_read, c_hash_function. Loads 16 message words, runs 64 rounds (one per cycle), and adds the
//  working variables into the chaining state. Presents a 256-bit digest with a one-cycle valid pulse.
//  Supports multi-block chaining, e.g. the 80-byte block header as 2 blocks. Illegal command sequences raise a sticky error.
// PARAMETERS
//  ROUNDS     64  compression rounds per block; fixed by SHA-256, must stay 64
//  MSG_WORDS  16  32-bit message words per block; sizes the schedule ring
// PORTS
//  clk              in   1    system clock; all state updates on rising edge
//  reset            in   1    asynchronous, active-high reset
//  start            in   1    begin new job: chaining state <= IV; has priority over c_hash_function
//  c_read           in   1    msg_word is valid this cycle; qualifies CMD_LOAD only
//  c_hash_function  in   3    command: 0 HOLD, 1 LOAD, 2 ROUND, 3 ADD, 4-7 illegal
//  msg_word         in   32   message word, big-endian word order, W[0] first
//  round_idx        out  6    index of the next round to execute (0..63)
//  busy             out  1    high in LOAD, ROUND, ADD states
//  digest           out  256  H0..H7, H0 in bits [255:224]; holds until next start or reset
//  digest_valid     out  1    one-cycle pulse, the cycle after ADD completes
//  cmd_err          out  1    sticky illegal-command flag; cleared by start or reset
// BEHAVIOUR
//  Reset: state=IDLE; H0..H7=IV; a..h=0; W ring=0; load_cnt=0; round_idx=0; busy=0; digest=0; digest_valid=0; cmd_err=0.
//  FSM states: IDLE, LOAD, ROUND, ADD, DONE. HOLD (0) is legal in every state and changes nothing.
//  start (any state, incl. mid-round): H<=IV, a..h<=IV, load_cnt<=0, round_idx<=0, cmd_err<=0, ->LOAD.
//    The command in the same cycle is ignored.
//  LOAD: LOAD&&c_read -> W[load_cnt]<=msg_word, load_cnt++. On the 16th word -> ROUND, load_cnt<=0.
//    LOAD with !c_read is a stall (no write). c_read with any non-LOAD command is ignored.
//  ROUND: each ROUND command executes one FIPS 180-4 round t=round_idx with K[t].
//    W_t = ring[t] for t<16.
//    For t>=16: W_t = s1(ring[t-2]) + ring[t-7] + s0(ring[t-15]) + ring[t-16], mod 2^32 in a ring of 16.
//    W_t is written back into slot t mod 16.
//    All additions are 32-bit, carry discarded. round_idx increments. After t=63: round_idx<=0, ->ADD.
//  ADD: ADD command -> Hi<=Hi+{a..h}i mod 2^32; a..h<=new H; ->DONE.
//    digest<=new H; digest_valid=1 for exactly the next cycle.
//  DONE: LOAD&&c_read -> chained next block. The word is written to W[0], load_cnt<=1, H retained, ->LOAD.
//    ROUND/ADD in DONE are illegal.
//  Illegal: cmd 4-7 in any state; ROUND/ADD in LOAD; LOAD/ADD in ROUND; LOAD/ROUND in ADD; any non-HOLD in IDLE.
//    Result: cmd_err<=1, ->IDLE, counters cleared, H and digest unchanged.
//  Latency: start to digest_valid = 1 + 16 (loads) + 64 (rounds) + 1 (ADD) + 1 = 83 cycles with no stalls.
//  Reset mid-operation: immediate return to reset values; a partial block is discarded.
// CONFIGURATION
//  Macro SHA256_TARGET_CHECK_EN
//   Defined: adds input target[255:0] and output hit.
//     hit is registered, valid with digest_valid: 1 iff byte-reversed digest <= target (unsigned).
//     hit resets to 0 and clears on start.
//   Undefined: no target port, no hit port, no comparator logic.
// STRUCTURE
//  Package sha256_pkg: K[0:63] constant array, IV[0:7], cmd_e enum (HOLD/LOAD/ROUND/ADD), state_e enum.
//    Also Ch/Maj/S0/S1/s0/s1 functions.
//  Sub-module sha256_msg_schedule: 16x32 ring, write port (load), expansion logic, outputs W_t for round_idx.
//  Top: FSM, counters, working registers a..h, chaining H, digest/valid/err registers.
// TESTING
//  1 "abc" padded block (61626380 00000000..00000018), 16 LOAD + 64 ROUND + ADD
//    -> digest=ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad,
//       digest_valid one cycle, 83 cycles after start.
//  2 Two-block 448-bit "abcdbcdecdefdefg...nopq" chained through DONE->LOAD
//    -> 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
//  3 ROUND issued after only 5 LOADs -> cmd_err=1 next cycle, state IDLE, digest unchanged.
//    A subsequent start clears cmd_err.
//  4 c_read low on 4 LOAD cycles and HOLD on 10 ROUND cycles during test 1
//    -> same digest, digest_valid 14 cycles later.
//  5 reset asserted at round 30, released, then test 1 replayed -> all outputs at reset values, then the correct digest.
//  6 SHA256_TARGET_CHECK_EN: target=all-ones -> hit=1 with valid; target=0 -> hit=0; start mid-round
//    -> restart, correct digest.

Source files
------------

// File: rtl/sha256_pkg.sv
// SHA-256 constants, command/state encodings and the FIPS 180-4 bit functions
// shared by the hash engine and its message schedule.
package sha256_pkg;

  typedef enum logic [2:0] {
    CMD_HOLD  = 3'd0,
    CMD_LOAD  = 3'd1,
    CMD_ROUND = 3'd2,
    CMD_ADD   = 3'd3
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_ROUND, ST_ADD, ST_DONE
  } state_e;

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] IV [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, y, z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, y, z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_hash_engine_if.sv
// Command/result bundle between the mining control block (master) and the hash engine (slave).
// SHA256_TARGET_CHECK_EN adds the target input and hit result.
interface sha256_hash_engine_if;
  logic         start;
  logic         c_read;
  logic [2:0]   c_hash_function;
  logic [31:0]  msg_word;
  logic [5:0]   round_idx;
  logic         busy;
  logic [255:0] digest;
  logic         digest_valid;
  logic         cmd_err;
`ifdef SHA256_TARGET_CHECK_EN
  logic [255:0] target;
  logic         hit;
`endif

  modport master (
    output start, c_read, c_hash_function, msg_word,
`ifdef SHA256_TARGET_CHECK_EN
    output target, input hit,
`endif
    input  round_idx, busy, digest, digest_valid, cmd_err
  );

  modport slave (
    input  start, c_read, c_hash_function, msg_word,
`ifdef SHA256_TARGET_CHECK_EN
    input  target, output hit,
`endif
    output round_idx, busy, digest, digest_valid, cmd_err
  );
endinterface

// File: rtl/sha256_msg_schedule.sv
// 16-entry message schedule ring: loaded word by word, then expanded in place,
// slot t mod 16 being overwritten by W_t as each round executes.
module sha256_msg_schedule
  import sha256_pkg::*;
#(
  parameter  int MSG_WORDS = 16,
  localparam int IW        = $clog2(MSG_WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en_i,
  input  logic [IW-1:0] wr_idx_i,
  input  logic [31:0]   wr_data_i,
  input  logic          adv_i,
  input  logic [5:0]    t_i,
  output logic [31:0]   w_o
);

  logic [MSG_WORDS-1:0][31:0] ring_q;
  logic [IW-1:0]              slot, m2, m7, m15;
  logic [31:0]                w_exp;

  // ring[t-16] is the slot about to be overwritten, so it is read at index t itself
  always_comb begin
    slot  = t_i[IW-1:0];
    m2    = slot - IW'(2);
    m7    = slot - IW'(7);
    m15   = slot - IW'(15);
    w_exp = ssig1(ring_q[m2]) + ring_q[m7] + ssig0(ring_q[m15]) + ring_q[slot];
    w_o   = (t_i < 6'(MSG_WORDS)) ? ring_q[slot] : w_exp;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        ring_q           <= '0;
    else if (wr_en_i) ring_q[wr_idx_i] <= wr_data_i;
    else if (adv_i)   ring_q[slot]     <= w_o;
  end

endmodule

// File: rtl/sha256_hash_engine.sv
// Command-driven SHA-256 compression engine: LOAD 16 words, 64 ROUNDs, ADD into the chaining state.
// Optional SHA256_TARGET_CHECK_EN adds a registered byte-reversed digest <= target comparison (hit).
module sha256_hash_engine
  import sha256_pkg::*;
#(
  parameter int ROUNDS    = 64,
  parameter int MSG_WORDS = 16
) (
  input logic           clk,
  input logic           reset,
  sha256_hash_engine_if.slave bus
);

  localparam int IW = $clog2(MSG_WORDS);

  state_e               state_q, state_d;
  logic [IW-1:0]        load_cnt_q, load_cnt_d;
  logic [5:0]           round_q, round_d;
  logic [7:0][31:0]     wv_q, wv_d;     // a..h, index 0 = a
  logic [7:0][31:0]     h_q, h_d;       // H0..H7
  logic [255:0]         digest_q, digest_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;

  logic [2:0]           cmd;
  logic                 illegal, ld_we, adv;
  logic [IW-1:0]        ld_idx;
  logic [31:0]          w_t, t1, t2;
  logic [7:0][31:0]     rnd, hsum;
  logic [255:0]         dg_new;

  sha256_msg_schedule #(.MSG_WORDS(MSG_WORDS)) u_sched (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (ld_we),
    .wr_idx_i  (ld_idx),
    .wr_data_i (bus.msg_word),
    .adv_i     (adv),
    .t_i       (round_q),
    .w_o       (w_t)
  );

  always_comb begin
    t1 = wv_q[7] + bsig1(wv_q[4]) + ch(wv_q[4], wv_q[5], wv_q[6]) + K[round_q] + w_t;
    t2 = bsig0(wv_q[0]) + maj(wv_q[0], wv_q[1], wv_q[2]);
    rnd      = '0;
    rnd[7:1] = wv_q[6:0];
    rnd[4]   = wv_q[3] + t1;
    rnd[0]   = t1 + t2;
    dg_new   = '0;
    for (int i = 0; i < 8; i++) begin
      hsum[i]                = h_q[i] + wv_q[i];
      dg_new[255-32*i -: 32] = hsum[i];
    end
  end

`ifdef SHA256_TARGET_CHECK_EN
  logic         hit_q, hit_d;
  logic [255:0] dg_rev;

  always_comb begin
    for (int b = 0; b < 32; b++) dg_rev[8*b +: 8] = dg_new[255-8*b -: 8];
  end
`endif

  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    round_d    = round_q;
    wv_d       = wv_q;
    h_d        = h_q;
    digest_d   = digest_q;
    valid_d    = 1'b0;
    err_d      = err_q;
    illegal    = 1'b0;
    ld_we      = 1'b0;
    ld_idx     = load_cnt_q;
    adv        = 1'b0;
    cmd        = bus.c_hash_function;
`ifdef SHA256_TARGET_CHECK_EN
    hit_d      = hit_q;
`endif
    if (bus.start) begin
      for (int i = 0; i < 8; i++) begin
        h_d[i]  = IV[i];
        wv_d[i] = IV[i];
      end
      load_cnt_d = '0;
      round_d    = '0;
      err_d      = 1'b0;
      state_d    = ST_LOAD;
`ifdef SHA256_TARGET_CHECK_EN
      hit_d      = 1'b0;
`endif
    end else if (cmd > 3'(CMD_ADD)) begin
      illegal = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: illegal = (cmd != CMD_HOLD);
        ST_LOAD: begin
          if (cmd == CMD_LOAD && bus.c_read) begin
            ld_we = 1'b1;
            if (load_cnt_q == IW'(MSG_WORDS - 1)) begin
              load_cnt_d = '0;
              state_d    = ST_ROUND;
            end else begin
              load_cnt_d = load_cnt_q + 1'b1;
            end
          end
          illegal = (cmd == CMD_ROUND) || (cmd == CMD_ADD);
        end
        ST_ROUND: begin
          if (cmd == CMD_ROUND) begin
            adv  = 1'b1;
            wv_d = rnd;
            if (round_q == 6'(ROUNDS - 1)) begin
              round_d = '0;
              state_d = ST_ADD;
            end else begin
              round_d = round_q + 1'b1;
            end
          end
          illegal = (cmd == CMD_LOAD) || (cmd == CMD_ADD);
        end
        ST_ADD: begin
          if (cmd == CMD_ADD) begin
            h_d      = hsum;
            wv_d     = hsum;
            digest_d = dg_new;
            valid_d  = 1'b1;
            state_d  = ST_DONE;
`ifdef SHA256_TARGET_CHECK_EN
            hit_d    = (dg_rev <= bus.target);
`endif
          end
          illegal = (cmd == CMD_LOAD) || (cmd == CMD_ROUND);
        end
        ST_DONE: begin
          // first word of a chained block; H is kept as the new chaining input
          if (cmd == CMD_LOAD && bus.c_read) begin
            ld_we      = 1'b1;
            ld_idx     = '0;
            load_cnt_d = IW'(1);
            state_d    = ST_LOAD;
          end
          illegal = (cmd == CMD_ROUND) || (cmd == CMD_ADD);
        end
        default: illegal = 1'b1;
      endcase
    end
    if (illegal) begin
      err_d      = 1'b1;
      state_d    = ST_IDLE;
      load_cnt_d = '0;
      round_d    = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      load_cnt_q <= '0;
      round_q    <= '0;
      wv_q       <= '0;
      for (int i = 0; i < 8; i++) h_q[i] <= IV[i];
      digest_q   <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      round_q    <= round_d;
      wv_q       <= wv_d;
      h_q        <= h_d;
      digest_q   <= digest_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

`ifdef SHA256_TARGET_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) hit_q <= 1'b0;
    else       hit_q <= hit_d;
  end
  assign bus.hit = hit_q;
`endif

  assign bus.round_idx    = round_q;
  assign bus.busy         = (state_q == ST_LOAD) || (state_q == ST_ROUND) || (state_q == ST_ADD);
  assign bus.digest       = digest_q;
  assign bus.digest_valid = valid_q;
  assign bus.cmd_err      = err_q;

endmodule

// File: tb/tb_sha256_hash_engine.sv
// Self-checking bench for sha256_hash_engine: vector table of messages driven as command streams,
// digests checked through a scoreboard, plus hand sequences for errors, reset and restart.
module tb_sha256_hash_engine;
  import sha256_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sha256_hash_engine_if bus();
  sha256_hash_engine dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    int           nblk;
    logic [31:0]  w [0:31];
    int           stalls;
    int           holds;
    logic [255:0] exp;
    int           lat;
    bit           hit;
  } vec_t;

  typedef struct {
    logic [255:0] dg;
    bit           chk;
    int           lat;
    bit           hit;
  } sb_t;

  localparam logic [255:0] ABC_DG = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] TWO_DG = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  vec_t tbl [0:2];
  sb_t  sbq [$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  bit   prev_v = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // one command per cycle; called at #1 after a rising edge, returns at #1 after the next
  task automatic drive(input bit s, input logic [2:0] c, input bit rd, input logic [31:0] w);
    bus.start = s;
    bus.c_hash_function = c;
    bus.c_read = rd;
    bus.msg_word = w;
    if (s) start_cyc = cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    int  ns, nh;
    sb_t e;
    ns = 0;
    nh = 0;
`ifdef SHA256_TARGET_CHECK_EN
    bus.target = v.hit ? '1 : '0;
`endif
    drive(1'b1, CMD_HOLD, 1'b0, 32'h0);
    for (int b = 0; b < v.nblk; b++) begin
      for (int i = 0; i < 16; i++) begin
        if (i % 3 == 2 && ns < v.stalls) begin
          drive(1'b0, CMD_LOAD, 1'b0, 32'hdeadbeef);
          ns++;
        end
        drive(1'b0, CMD_LOAD, 1'b1, v.w[16*b+i]);
      end
      for (int r = 0; r < 64; r++) begin
        if (r % 6 == 3 && nh < v.holds) begin
          drive(1'b0, CMD_HOLD, 1'b0, 32'h0);
          nh++;
        end
        drive(1'b0, CMD_ROUND, 1'b0, 32'h0);
      end
      e.dg  = v.exp;
      e.chk = (b == v.nblk - 1);
      e.lat = e.chk ? v.lat : 0;
      e.hit = v.hit;
      sbq.push_back(e);
      drive(1'b0, CMD_ADD, 1'b0, 32'h0);
    end
    repeat (3) drive(1'b0, CMD_HOLD, 1'b0, 32'h0);
    check("pending", 256'(sbq.size()), 256'd0);
    check("digest_hold", bus.digest, v.exp);
    check("busy_done", 256'(bus.busy), 256'd0);
  endtask

  always @(negedge clk) begin
    sb_t e;
    if (reset) begin
      prev_v = 1'b0;
    end else begin
      if (bus.digest_valid) begin
        check("valid_width", 256'(prev_v), 256'd0);
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_valid: got digest_valid=1 want no pulse");
        end else begin
          e = sbq.pop_front();
          if (e.chk) check("digest", bus.digest, e.dg);
          if (e.lat > 0) check("latency", 256'(cyc - start_cyc + 1), 256'(e.lat));
`ifdef SHA256_TARGET_CHECK_EN
          check("hit", 256'(bus.hit), 256'(e.hit));
`endif
        end
      end
      prev_v = bus.digest_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want test done");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int t = 0; t < 3; t++) begin
      tbl[t].nblk = 1; tbl[t].stalls = 0; tbl[t].holds = 0;
      tbl[t].lat = 0; tbl[t].hit = 1'b1; tbl[t].exp = ABC_DG;
      for (int i = 0; i < 32; i++) tbl[t].w[i] = 32'h0;
    end
    tbl[0].w[0] = 32'h61626380; tbl[0].w[15] = 32'h00000018; tbl[0].lat = 83;
    tbl[2] = tbl[0];
    tbl[2].stalls = 4; tbl[2].holds = 10; tbl[2].lat = 97;
    tbl[1].nblk = 2; tbl[1].exp = TWO_DG; tbl[1].hit = 1'b0;
    tbl[1].w[0]  = 32'h61626364; tbl[1].w[1]  = 32'h62636465; tbl[1].w[2]  = 32'h63646566;
    tbl[1].w[3]  = 32'h64656667; tbl[1].w[4]  = 32'h65666768; tbl[1].w[5]  = 32'h66676869;
    tbl[1].w[6]  = 32'h6768696a; tbl[1].w[7]  = 32'h68696a6b; tbl[1].w[8]  = 32'h696a6b6c;
    tbl[1].w[9]  = 32'h6a6b6c6d; tbl[1].w[10] = 32'h6b6c6d6e; tbl[1].w[11] = 32'h6c6d6e6f;
    tbl[1].w[12] = 32'h6d6e6f70; tbl[1].w[13] = 32'h6e6f7071; tbl[1].w[14] = 32'h80000000;
    tbl[1].w[31] = 32'h000001c0;

    bus.start = 1'b0; bus.c_read = 1'b0; bus.c_hash_function = CMD_HOLD; bus.msg_word = 32'h0;
`ifdef SHA256_TARGET_CHECK_EN
    bus.target = '0;
`endif
    repeat (2) @(negedge clk);
    check("rst_round_idx", 256'(bus.round_idx), 256'd0);
    check("rst_busy", 256'(bus.busy), 256'd0);
    check("rst_digest", bus.digest, 256'd0);
    check("rst_valid", 256'(bus.digest_valid), 256'd0);
    check("rst_err", 256'(bus.cmd_err), 256'd0);
`ifdef SHA256_TARGET_CHECK_EN
    check("rst_hit", 256'(bus.hit), 256'd0);
`endif
    @(posedge clk); #1;
    reset = 1'b0;
    drive(1'b0, CMD_HOLD, 1'b1, 32'h0);
    check("idle_hold_ok", 256'(bus.cmd_err), 256'd0);

    for (int t = 0; t < 3; t++) run_vec(tbl[t]);

    // ROUND after only 5 LOADs
    drive(1'b1, CMD_HOLD, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) drive(1'b0, CMD_LOAD, 1'b1, 32'h11111111 * i);
    check("load_busy", 256'(bus.busy), 256'd1);
    drive(1'b0, CMD_ROUND, 1'b0, 32'h0);
    check("err_set", 256'(bus.cmd_err), 256'd1);
    check("err_idle", 256'(bus.busy), 256'd0);
    check("err_round_idx", 256'(bus.round_idx), 256'd0);
    check("err_digest", bus.digest, ABC_DG);
    drive(1'b0, 3'd5, 1'b0, 32'h0);
    check("err_sticky", 256'(bus.cmd_err), 256'd1);
    drive(1'b1, CMD_ADD, 1'b0, 32'h0);
    check("start_clr_err", 256'(bus.cmd_err), 256'd0);
    check("start_busy", 256'(bus.busy), 256'd1);
    drive(1'b0, CMD_ADD, 1'b0, 32'h0);
    check("add_in_load_err", 256'(bus.cmd_err), 256'd1);

    // reset at round 30
    drive(1'b1, CMD_HOLD, 1'b0, 32'h0);
    for (int i = 0; i < 16; i++) drive(1'b0, CMD_LOAD, 1'b1, tbl[0].w[i]);
    for (int r = 0; r < 30; r++) drive(1'b0, CMD_ROUND, 1'b0, 32'h0);
    check("mid_round_idx", 256'(bus.round_idx), 256'd30);
    reset = 1'b1;
    bus.c_hash_function = CMD_HOLD;
    #2;
    check("mid_rst_round_idx", 256'(bus.round_idx), 256'd0);
    check("mid_rst_busy", 256'(bus.busy), 256'd0);
    check("mid_rst_digest", bus.digest, 256'd0);
    check("mid_rst_err", 256'(bus.cmd_err), 256'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    run_vec(tbl[0]);

    // start mid-round restarts the job
    drive(1'b1, CMD_HOLD, 1'b0, 32'h0);
    for (int i = 0; i < 16; i++) drive(1'b0, CMD_LOAD, 1'b1, 32'h5a5a0000 + i);
    for (int r = 0; r < 20; r++) drive(1'b0, CMD_ROUND, 1'b0, 32'h0);
    run_vec(tbl[1]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
